// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Execute-stage front end for a combinational 32-bit ALU.
//   - 2-entry op FIFO (circular pointers plus count)
//   - X slot: registered operands/opcode driving the ALU
//   - W slot: registered ALU result with valid/ready backpressure
//   - RAW resolution between back-to-back ops
// Build option: define ALU_FWD_EN to forward from X/W at issue. When it is
// undefined there are no forwarding muxes; instead the FIFO head interlocks
// until its producer has left both X and W.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream op handshake
//   in_a, in_b, in_func       operand values and ALU opcode (passed through)
//   in_rs1, in_rs2, in_rd     source/destination indices (0 = none)
//   alu_a, alu_b, alu_func    X-slot drive to the ALU
//   alu_res, alu_zero         combinational ALU result and zero flag
//   wb_valid/wb_ready         W-slot handshake to downstream
//   wb_rd, wb_data, wb_zero   W-slot contents
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [3:0]      in_func,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [RW-1:0]   in_rd,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_func,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_zero,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_zero
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      func;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
    } op_t;

    op_t             fifo_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      cnt_q, cnt_d;

    logic            x_valid_q;
    logic [XLEN-1:0] x_a_q, x_b_q;
    logic [3:0]      x_func_q;
    logic [RW-1:0]   x_rd_q;

    logic            wb_valid_q;
    logic [RW-1:0]   wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_zero_q;

    op_t             head;
    logic            w_adv, x_adv, issue, push, interlock;
    logic [XLEN-1:0] op_a, op_b;

    assign head  = fifo_q[rd_ptr_q];
    assign w_adv = !wb_valid_q || wb_ready;
    assign x_adv = !x_valid_q || w_adv;

    // Held low while rst is asserted so nothing is accepted during reset.
    assign in_ready = !rst && (cnt_q != 2'd2);
    assign push     = in_valid && in_ready;
    assign issue    = (cnt_q != 2'd0) && x_adv && !interlock;

`ifdef ALU_FWD_EN
    assign interlock = 1'b0;

    // X holds the newer producer, so it wins over W.
    always_comb begin
        op_a = head.a;
        op_b = head.b;
        if (head.rs1 != '0) begin
            if (x_valid_q && x_rd_q == head.rs1)
                op_a = alu_res;
            else if (wb_valid_q && wb_rd_q == head.rs1)
                op_a = wb_data_q;
        end
        if (head.rs2 != '0) begin
            if (x_valid_q && x_rd_q == head.rs2)
                op_b = alu_res;
            else if (wb_valid_q && wb_rd_q == head.rs2)
                op_b = wb_data_q;
        end
    end
`else
    function automatic logic hazard(input logic [RW-1:0] rs);
        return (rs != '0) &&
               ((x_valid_q && x_rd_q == rs) || (wb_valid_q && wb_rd_q == rs));
    endfunction

    assign interlock = hazard(head.rs1) || hazard(head.rs2);
    assign op_a      = head.a;
    assign op_b      = head.b;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (push && !issue)
            cnt_d = cnt_q + 2'd1;
        else if (!push && issue)
            cnt_d = cnt_q - 2'd1;
    end

    // FIFO storage needs no reset; count and pointers qualify it.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= '{a: in_a, b: in_b, func: in_func,
                                  rs1: in_rs1, rs2: in_rs2, rd: in_rd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            x_valid_q  <= 1'b0;
            x_a_q      <= '0;
            x_b_q      <= '0;
            x_func_q   <= '0;
            x_rd_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_zero_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push)
                wr_ptr_q <= !wr_ptr_q;
            if (issue)
                rd_ptr_q <= !rd_ptr_q;

            if (x_adv) begin
                x_valid_q <= issue;
                if (issue) begin
                    x_a_q    <= op_a;
                    x_b_q    <= op_b;
                    x_func_q <= head.func;
                    x_rd_q   <= head.rd;
                end
            end

            if (w_adv) begin
                wb_valid_q <= x_valid_q;
                if (x_valid_q) begin
                    wb_rd_q   <= x_rd_q;
                    wb_data_q <= alu_res;
                    wb_zero_q <= alu_zero;
                end
            end
        end
    end

    assign alu_a    = x_a_q;
    assign alu_b    = x_b_q;
    assign alu_func = x_func_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_zero  = wb_zero_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;

`ifdef ALU_FWD_EN
    localparam int DEP_GAP = 1;
`else
    localparam int DEP_GAP = 3;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a, in_b;
    logic [3:0]      in_func;
    logic [RW-1:0]   in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0] alu_a, alu_b;
    logic [3:0]      alu_func;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic            wb_valid;
    logic            wb_ready;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_zero;

    alu_issue_stage #(.XLEN(XLEN), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_func(in_func),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero)
    );

    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        case (alu_func)
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a - alu_b;
            4'd2:    alu_res = alu_a & alu_b;
            4'd3:    alu_res = alu_a | alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
    end
    assign alu_zero = (alu_res == '0);

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            zero;
        int              c;
    } wb_t;
    wb_t obs[$];

    always @(negedge clk)
        if (!rst && wb_valid && wb_ready)
            obs.push_back('{wb_rd, wb_data, wb_zero, cyc});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_func = f;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
        in_a = '0; in_b = '0; in_func = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_func", 32'(alu_func), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_zero", 32'(wb_zero), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // Single op latency: X one edge after accept, W two edges after
        push_op(32'd7, 32'd5, F_ADD, 5'd0, 5'd0, 5'd3);
        @(posedge clk); @(negedge clk);
        chk("single_alu_a", alu_a, 32'd7);
        chk("single_alu_b", alu_b, 32'd5);
        chk("single_alu_func", 32'(alu_func), 32'(F_ADD));
        @(posedge clk); @(negedge clk);
        chk("single_wb_valid", 32'(wb_valid), 32'd1);
        chk("single_wb_rd", 32'(wb_rd), 32'd3);
        chk("single_wb_data", wb_data, 32'd12);
        chk("single_wb_zero", 32'(wb_zero), 32'd0);
        idle(3);

        // Back-to-back RAW on rs1; without forwarding the upstream supplies
        // the already-written value, with forwarding it is stale (0).
        obs.delete();
        push_op(32'd10, 32'd1, F_ADD, 5'd0, 5'd0, 5'd4);
`ifdef ALU_FWD_EN
        push_op(32'd0, 32'd2, F_SUB, 5'd4, 5'd0, 5'd6);
`else
        push_op(32'd11, 32'd2, F_SUB, 5'd4, 5'd0, 5'd6);
`endif
        idle(8);
        chk("raw_count", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            chk("raw_prod", obs[0].data, 32'd11);
            chk("raw_cons", obs[1].data, 32'd9);
            chk("raw_cons_rd", 32'(obs[1].rd), 32'd6);
            chk("raw_gap", 32'(obs[1].c - obs[0].c), 32'(DEP_GAP));
        end

        // X beats W when both hold rd=5
        obs.delete();
        push_op(32'd100, 32'd0, F_ADD, 5'd0, 5'd0, 5'd5);
        push_op(32'd200, 32'd0, F_ADD, 5'd0, 5'd0, 5'd5);
`ifdef ALU_FWD_EN
        push_op(32'd0, 32'd1, F_ADD, 5'd5, 5'd0, 5'd7);
`else
        push_op(32'd200, 32'd1, F_ADD, 5'd5, 5'd0, 5'd7);
`endif
        idle(10);
        chk("prio_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            chk("prio_data", obs[2].data, 32'd201);
            chk("prio_rd", 32'(obs[2].rd), 32'd7);
        end

        // rd=0 producer, rs1=0 consumer: no dependency; plus a zero result
        obs.delete();
        push_op(32'd1, 32'd2, F_ADD, 5'd0, 5'd0, 5'd0);
        push_op(32'd40, 32'd2, F_ADD, 5'd0, 5'd0, 5'd8);
        push_op(32'd5, 32'd5, F_SUB, 5'd0, 5'd0, 5'd9);
        idle(8);
        chk("rd0_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            chk("rd0_cons", obs[1].data, 32'd42);
            chk("rd0_gap", 32'(obs[1].c - obs[0].c), 32'd1);
            chk("rd0_nz", 32'(obs[0].zero), 32'd0);
            chk("zero_flag", 32'(obs[2].zero), 32'd1);
            chk("zero_data", obs[2].data, 32'd0);
        end

        // Backpressure: four accepts fill W, X and both FIFO entries
        obs.delete();
        wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            push_op(32'(i * 10), 32'd1, F_ADD, 5'd0, 5'd0, 5'(10 + i));
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_alu_a", alu_a, 32'd20);
        chk("bp_wb_data", wb_data, 32'd11);
        idle(3);
        @(negedge clk);
        chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
        chk("bp_alu_a_hold", alu_a, 32'd20);
        chk("bp_wb_rd_hold", 32'(wb_rd), 32'd11);
        @(posedge clk); #1; wb_ready = 1'b1;
        idle(10);
        chk("bp_count", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            chk("bp_order_data", obs[i].data, 32'((i + 1) * 10 + 1));
            chk("bp_order_rd", 32'(obs[i].rd), 32'(11 + i));
        end

        // Reset while X and W are occupied
        obs.delete();
        wb_ready = 1'b0;
        push_op(32'd50, 32'd1, F_ADD, 5'd0, 5'd0, 5'd20);
        push_op(32'd60, 32'd1, F_ADD, 5'd0, 5'd0, 5'd21);
        idle(1);
        @(negedge clk);
        chk("mid_pre_wb_valid", 32'(wb_valid), 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_alu_a", alu_a, 32'd0);
        wb_ready = 1'b1;
        idle(6);
        chk("mid_no_ghost", 32'(obs.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
